// File: rtl/spcpu_mem_arbiter_pkg.sv
// Shared types for the spcpu memory arbiter: FSM states, master id, access-size
// encodings and the write-lane helper.
package spcpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    typedef logic arb_id_t;

    localparam int   ARB_MAX_WAIT_DEFAULT = 255;
    localparam logic CPU_DATA_ACC_SZ_8    = 1'b0;
    localparam logic CPU_DATA_ACC_SZ_16   = 1'b1;

    typedef struct packed {
        logic we_16;
        logic we_8;
    } arb_lane_we_t;

    // Only the lane that matches the access size may see a write enable.
    function automatic arb_lane_we_t arb_lane_we(input logic we, input logic acc_sz);
        arb_lane_we_t lanes;
        lanes.we_8  = we && (acc_sz == CPU_DATA_ACC_SZ_8);
        lanes.we_16 = we && (acc_sz == CPU_DATA_ACC_SZ_16);
        return lanes;
    endfunction

endpackage

// File: rtl/spcpu_mem_arbiter_if.sv
// Bus bundle between the two requesters (r0 = spcpu core, r1 = DMA/debug loader),
// the arbiter and the single memory port. slave = arbiter side, master = environment side.
interface spcpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  r0_req_rdwr;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic                  r0_data_acc_sz;
    logic                  r0_we;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic [DATA_WIDTH-1:0] r0_rdata;
    logic                  r0_data_ready;

    logic                  r1_req_rdwr;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic                  r1_data_acc_sz;
    logic                  r1_we;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic [DATA_WIDTH-1:0] r1_rdata;
    logic                  r1_data_ready;

    logic                  mem_req_rdwr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_data_acc_sz;
    logic                  mem_we_8;
    logic                  mem_we_16;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [7:0]            mem_rdata_8;
    logic [DATA_WIDTH-1:0] mem_rdata_16;
    logic                  mem_data_ready;

    logic                  grant_id;
    logic                  timeout_err;

    modport slave (
        input  r0_req_rdwr, r0_addr, r0_data_acc_sz, r0_we, r0_wdata,
        output r0_rdata, r0_data_ready,
        input  r1_req_rdwr, r1_addr, r1_data_acc_sz, r1_we, r1_wdata,
        output r1_rdata, r1_data_ready,
        output mem_req_rdwr, mem_addr, mem_data_acc_sz, mem_we_8, mem_we_16, mem_wdata,
        input  mem_rdata_8, mem_rdata_16, mem_data_ready,
        output grant_id, timeout_err
    );

    modport master (
        output r0_req_rdwr, r0_addr, r0_data_acc_sz, r0_we, r0_wdata,
        input  r0_rdata, r0_data_ready,
        output r1_req_rdwr, r1_addr, r1_data_acc_sz, r1_we, r1_wdata,
        input  r1_rdata, r1_data_ready,
        input  mem_req_rdwr, mem_addr, mem_data_acc_sz, mem_we_8, mem_we_16, mem_wdata,
        output mem_rdata_8, mem_rdata_16, mem_data_ready,
        input  grant_id, timeout_err
    );

endinterface

// File: rtl/spcpu_mem_arbiter_pick.sv
// Combinational winner select for the arbiter. Build option: ARB_ROUND_ROBIN_EN
// (defined = alternate on ties, undefined = r0 fixed priority).
module spcpu_arb_pick
    import spcpu_mem_arbiter_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
    input  arb_id_t last_winner_i,
    output arb_id_t win_o,
    output logic    any_o
);

    assign any_o = req0_i | req1_i;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        win_o = 1'b0;
        if (req0_i && req1_i) begin
            win_o = ~last_winner_i;
        end else if (req1_i) begin
            win_o = 1'b1;
        end
    end
`else
    // History has no loads here; the register feeding it is swept in synthesis.
    logic unused_last_winner;
    assign unused_last_winner = last_winner_i;

    always_comb begin
        win_o = 1'b0;
        if (!req0_i && req1_i) begin
            win_o = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/spcpu_mem_arbiter.sv
// Two-master arbiter for the single memory port: one access in flight, grant held
// until memory completes, with watchdog abort. Build option: ARB_ROUND_ROBIN_EN.
module spcpu_mem_arbiter
    import spcpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = ARB_MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    spcpu_mem_arbiter_if.slave bus
);

    // state     | meaning
    // ARB_IDLE  | no access in flight, waiting for a request
    // ARB_ISSUE | one-cycle request pulse to memory, watchdog cleared
    // ARB_WAIT  | waiting for memory completion or watchdog expiry
    // ARB_DONE  | one-cycle completion pulse to the owning master

    arb_state_t            state_q, state_d;
    arb_id_t               grant_q, grant_d;
    arb_id_t               last_winner_q, last_winner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  acc_sz_q, acc_sz_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    arb_id_t               pick_win;
    logic                  pick_any;
    logic                  wait_expired;
    logic [DATA_WIDTH-1:0] mem_rdata_sel;
    arb_lane_we_t          lane_we;

    spcpu_arb_pick u_pick (
        .req0_i        (bus.r0_req_rdwr),
        .req1_i        (bus.r1_req_rdwr),
        .last_winner_i (last_winner_q),
        .win_o         (pick_win),
        .any_o         (pick_any)
    );

    assign wait_expired  = (wait_cnt_q == 8'(MAX_WAIT));
    assign mem_rdata_sel = (acc_sz_q == CPU_DATA_ACC_SZ_8)
                         ? {{(DATA_WIDTH-8){1'b0}}, bus.mem_rdata_8}
                         : bus.mem_rdata_16;
    assign lane_we       = arb_lane_we(we_q, acc_sz_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (bus.mem_data_ready || wait_expired) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req_rdwr  = (state_q == ARB_ISSUE);
        bus.mem_we_8      = 1'b0;
        bus.mem_we_16     = 1'b0;
        bus.r0_data_ready = 1'b0;
        bus.r1_data_ready = 1'b0;
        if (state_q == ARB_ISSUE || state_q == ARB_WAIT) begin
            bus.mem_we_8  = lane_we.we_8;
            bus.mem_we_16 = lane_we.we_16;
        end
        if (state_q == ARB_DONE) begin
            bus.r0_data_ready = (grant_q == 1'b0);
            bus.r1_data_ready = (grant_q == 1'b1);
        end
    end

    assign bus.mem_addr        = addr_q;
    assign bus.mem_data_acc_sz = acc_sz_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.grant_id        = grant_q;
    assign bus.timeout_err     = timeout_q;
    assign bus.r0_rdata        = rdata0_q;
    assign bus.r1_rdata        = rdata1_q;

    always_comb begin
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        addr_d        = addr_q;
        acc_sz_d      = acc_sz_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d       = pick_win;
                    last_winner_d = pick_win;
                    if (pick_win == 1'b0) begin
                        addr_d   = bus.r0_addr;
                        acc_sz_d = bus.r0_data_acc_sz;
                        we_d     = bus.r0_we;
                        wdata_d  = bus.r0_wdata;
                    end else begin
                        addr_d   = bus.r1_addr;
                        acc_sz_d = bus.r1_data_acc_sz;
                        we_d     = bus.r1_we;
                        wdata_d  = bus.r1_wdata;
                    end
                end
            end
            ARB_ISSUE: wait_cnt_d = 8'd0;
            ARB_WAIT: begin
                // A real completion wins over a watchdog expiring in the same cycle.
                if (bus.mem_data_ready) begin
                    if (grant_q == 1'b0) rdata0_d = mem_rdata_sel;
                    else                 rdata1_d = mem_rdata_sel;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    if (grant_q == 1'b0) rdata0_d = '0;
                    else                 rdata1_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ARB_DONE: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q       <= 1'b0;
            last_winner_q <= 1'b1;
            addr_q        <= '0;
            acc_sz_q      <= 1'b0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wait_cnt_q    <= 8'd0;
            timeout_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            addr_q        <= addr_d;
            acc_sz_q      <= acc_sz_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Directed bench for spcpu_mem_arbiter; expected grant order follows ARB_ROUND_ROBIN_EN.
module tb_spcpu_mem_arbiter;
    import spcpu_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   memreq_cnt = 0;
    int   pulse0 = 0;
    int   pulse1 = 0;

    spcpu_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    spcpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_req_rdwr)  memreq_cnt <= memreq_cnt + 1;
        if (bus.r0_data_ready) pulse0 <= pulse0 + 1;
        if (bus.r1_data_ready) pulse1 <= pulse1 + 1;
    end

    // results captured by xfer
    logic [15:0] iss_addr, iss_wdata, done_rdata;
    logic        iss_grant, iss_we8, iss_we16, wait_we8, wait_we16, wait_req;
    logic        done_rdy0, done_rdy1, idle_rdy;
    int          req_base, p0_base, p1_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!bus.mem_req_rdwr && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, bus.mem_req_rdwr}, 32'd1);
    endtask

    task automatic xfer(input logic id, input logic [15:0] a, input logic sz, input logic we,
                        input logic [15:0] wd, input int lat, input logic [15:0] r16, input logic [7:0] r8);
        req_base = memreq_cnt;
        p0_base  = pulse0;
        p1_base  = pulse1;
        if (id == 1'b0) begin
            bus.r0_addr = a; bus.r0_data_acc_sz = sz; bus.r0_we = we; bus.r0_wdata = wd;
            bus.r0_req_rdwr = 1'b1;
        end else begin
            bus.r1_addr = a; bus.r1_data_acc_sz = sz; bus.r1_we = we; bus.r1_wdata = wd;
            bus.r1_req_rdwr = 1'b1;
        end
        wait_issue("issue_seen");
        iss_addr  = bus.mem_addr;
        iss_wdata = bus.mem_wdata;
        iss_grant = bus.grant_id;
        iss_we8   = bus.mem_we_8;
        iss_we16  = bus.mem_we_16;
        tick();
        wait_we8  = bus.mem_we_8;
        wait_we16 = bus.mem_we_16;
        wait_req  = bus.mem_req_rdwr;
        repeat (lat - 1) tick();
        bus.mem_data_ready = 1'b1;
        bus.mem_rdata_16   = r16;
        bus.mem_rdata_8    = r8;
        tick();
        bus.mem_data_ready = 1'b0;
        done_rdy0  = bus.r0_data_ready;
        done_rdy1  = bus.r1_data_ready;
        done_rdata = id ? bus.r1_rdata : bus.r0_rdata;
        bus.r0_req_rdwr = 1'b0;
        bus.r1_req_rdwr = 1'b0;
        tick();
        idle_rdy = bus.r0_data_ready | bus.r1_data_ready;
    endtask

    initial begin
        int  n;
        logic exp_g;
        bus.r0_req_rdwr = 0; bus.r0_addr = 0; bus.r0_data_acc_sz = 0; bus.r0_we = 0; bus.r0_wdata = 0;
        bus.r1_req_rdwr = 0; bus.r1_addr = 0; bus.r1_data_acc_sz = 0; bus.r1_we = 0; bus.r1_wdata = 0;
        bus.mem_rdata_8 = 0; bus.mem_rdata_16 = 0; bus.mem_data_ready = 0;

        repeat (3) tick();
        chk("rst_mem_req", {31'd0, bus.mem_req_rdwr}, 32'd0);
        chk("rst_grant", {31'd0, bus.grant_id}, 32'd0);
        chk("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_r0_rdata", {16'd0, bus.r0_rdata}, 32'd0);
        chk("rst_we", {30'd0, bus.mem_we_16, bus.mem_we_8}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: r0 16-bit read, memory answers on the second WAIT cycle
        xfer(1'b0, 16'h0010, CPU_DATA_ACC_SZ_16, 1'b0, 16'h0000, 2, 16'hBEEF, 8'h11);
        chk("t1_addr", {16'd0, iss_addr}, 32'h0010);
        chk("t1_grant", {31'd0, iss_grant}, 32'd0);
        chk("t1_req_one_cycle", {31'd0, wait_req}, 32'd0);
        chk("t1_req_pulses", memreq_cnt - req_base, 32'd1);
        chk("t1_ready_done", {30'd0, done_rdy1, done_rdy0}, 32'b01);
        chk("t1_rdata", {16'd0, done_rdata}, 32'hBEEF);
        chk("t1_ready_cleared", {31'd0, idle_rdy}, 32'd0);
        chk("t1_pulse_count", pulse0 - p0_base, 32'd1);

        // 2: r1 8-bit write
        xfer(1'b1, 16'h0021, CPU_DATA_ACC_SZ_8, 1'b1, 16'h00A5, 1, 16'h0000, 8'h00);
        chk("t2_addr", {16'd0, iss_addr}, 32'h0021);
        chk("t2_grant", {31'd0, iss_grant}, 32'd1);
        chk("t2_we_issue", {30'd0, iss_we16, iss_we8}, 32'b01);
        chk("t2_we_wait", {30'd0, wait_we16, wait_we8}, 32'b01);
        chk("t2_wdata_lo", {24'd0, iss_wdata[7:0]}, 32'h00A5);
        chk("t2_r1_pulses", pulse1 - p1_base, 32'd1);
        chk("t2_r0_pulses", pulse0 - p0_base, 32'd0);
        chk("t2_r0_rdata_held", {16'd0, bus.r0_rdata}, 32'hBEEF);
        chk("t2_we_idle", {30'd0, bus.mem_we_16, bus.mem_we_8}, 32'd0);

        // 6: 8-bit read zero-extends the byte lane
        xfer(1'b1, 16'h0003, CPU_DATA_ACC_SZ_8, 1'b0, 16'h0000, 1, 16'h1234, 8'h7C);
        chk("t6_rdata", {16'd0, bus.r1_rdata}, 32'h007C);
        chk("t6_we_none", {30'd0, iss_we16, iss_we8}, 32'd0);

        // 4: watchdog with MAX_WAIT=8
        bus.mem_rdata_16 = 16'hFFFF;
        bus.mem_rdata_8  = 8'hFF;
        bus.r1_addr = 16'h0030; bus.r1_data_acc_sz = CPU_DATA_ACC_SZ_16; bus.r1_we = 1'b0;
        bus.r1_req_rdwr = 1'b1;
        wait_issue("t4_issue");
        n = 0;
        while (!bus.r1_data_ready && n < 30) begin
            tick();
            n++;
        end
        chk("t4_latency", n, 32'd10);
        chk("t4_rdata_zero", {16'd0, bus.r1_rdata}, 32'd0);
        chk("t4_timeout", {31'd0, bus.timeout_err}, 32'd1);
        bus.r1_req_rdwr = 1'b0;
        repeat (3) tick();
        chk("t4_timeout_sticky", {31'd0, bus.timeout_err}, 32'd1);

        // 3: both requesters held across four transactions
        bus.r0_addr = 16'h0100; bus.r0_data_acc_sz = CPU_DATA_ACC_SZ_16; bus.r0_we = 1'b0;
        bus.r1_addr = 16'h0200; bus.r1_data_acc_sz = CPU_DATA_ACC_SZ_16; bus.r1_we = 1'b0;
        bus.r0_req_rdwr = 1'b1;
        bus.r1_req_rdwr = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 1);
`else
            exp_g = 1'b0;
`endif
            wait_issue("t3_issue");
            chk($sformatf("t3_grant%0d", k), {31'd0, bus.grant_id}, {31'd0, exp_g});
            chk($sformatf("t3_addr%0d", k), {16'd0, bus.mem_addr}, exp_g ? 32'h0200 : 32'h0100);
            tick();
            bus.mem_data_ready = 1'b1;
            tick();
            bus.mem_data_ready = 1'b0;
            chk($sformatf("t3_ready%0d", k), {30'd0, bus.r1_data_ready, bus.r0_data_ready},
                exp_g ? 32'b10 : 32'b01);
            tick();
        end
        bus.r0_req_rdwr = 1'b0;
        bus.r1_req_rdwr = 1'b0;
        repeat (6) tick();

        // 5: reset asserted while waiting on memory
        bus.r0_addr = 16'h0040; bus.r0_we = 1'b0;
        bus.r0_req_rdwr = 1'b1;
        wait_issue("t5_issue");
        tick();
        p0_base = pulse0;
        p1_base = pulse1;
        reset = 1'b1;
        #2;
        bus.r0_req_rdwr = 1'b0;
        reset = 1'b0;
        tick();
        chk("t5_mem_req", {31'd0, bus.mem_req_rdwr}, 32'd0);
        chk("t5_we", {30'd0, bus.mem_we_16, bus.mem_we_8}, 32'd0);
        chk("t5_grant", {31'd0, bus.grant_id}, 32'd0);
        chk("t5_timeout_cleared", {31'd0, bus.timeout_err}, 32'd0);
        chk("t5_rdata", {bus.r1_rdata, bus.r0_rdata}, 32'd0);
        chk("t5_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        bus.mem_data_ready = 1'b1;
        repeat (4) tick();
        bus.mem_data_ready = 1'b0;
        chk("t5_no_pulse", (pulse0 - p0_base) + (pulse1 - p1_base), 32'd0);
        chk("t5_no_issue", {31'd0, bus.mem_req_rdwr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
